// File: rtl/l1_dcache_sa_pkg.sv
// Shared types for the set-associative L1 data cache: controller states,
// address-field width helpers and the per-line metadata record.
package l1_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_REFILL,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Widest tag the metadata record can hold; narrower tags are
    // zero-extended so every way compares the full field.
    localparam int TAG_MAX = 16;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
    } line_meta_t;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets,
                                 input int words);
        return addr_w - $clog2(sets) - $clog2(words);
    endfunction

endpackage

// File: rtl/l1_dcache_sa_if.sv
// Bundle of core request/response, flush/stall and L2 refill/write signals.
// slave = cache side, master = core + L2 side.
interface l1_dcache_sa_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              flush;
    logic              l2_busy;
    logic              l2_rd_req;
    logic [ADDR_W-1:0] l2_rd_addr;
    logic              l2_rd_valid;
    logic [DATA_W-1:0] l2_rd_data;
    logic              l2_wr_req;
    logic [ADDR_W-1:0] l2_wr_addr;
    logic [DATA_W-1:0] l2_wr_data;
    logic              l2_wr_ack;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  flush, l2_busy,
        input  l2_rd_valid, l2_rd_data, l2_wr_ack,
        output req_ready, resp_valid, resp_rdata,
        output l2_rd_req, l2_rd_addr,
        output l2_wr_req, l2_wr_addr, l2_wr_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output flush, l2_busy,
        output l2_rd_valid, l2_rd_data, l2_wr_ack,
        input  req_ready, resp_valid, resp_rdata,
        input  l2_rd_req, l2_rd_addr,
        input  l2_wr_req, l2_wr_addr, l2_wr_data
    );

endinterface

// File: rtl/l1_dcache_sa_tag_way.sv
// l1_tag_way: one way's valid/tag array. Ports: clk, reset, clear_all
// (invalidate every set), wr_en/idx/tag (install line), hit/valid for idx.
module l1_tag_way
    import l1_cache_pkg::*;
#(
    parameter int SETS  = 32,
    parameter int TAG_W = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_all,
    input  logic                    wr_en,
    input  logic [$clog2(SETS)-1:0] idx,
    input  logic [TAG_W-1:0]        tag,
    output logic                    hit,
    output logic                    valid
);

    line_meta_t meta_q [SETS];
    line_meta_t cur;

    assign cur   = meta_q[idx];
    assign valid = cur.valid;
    assign hit   = cur.valid && (cur.tag == TAG_MAX'(tag));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                meta_q[s] <= '0;
            end
        end else if (clear_all) begin
            for (int s = 0; s < SETS; s++) begin
                meta_q[s].valid <= 1'b0;
            end
        end else if (wr_en) begin
            meta_q[idx] <= '{valid: 1'b1, tag: TAG_MAX'(tag)};
        end
    end

endmodule

// File: rtl/l1_dcache_sa.sv
// Set-associative write-through / no-write-allocate L1 data cache.
// Ports: clk, reset (async, active-high), bus (l1_dcache_sa_if.slave);
// with L1_DCACHE_STATS_EN defined also hit_count / miss_count outputs.
module l1_dcache_sa
    import l1_cache_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int SETS   = 32,
    parameter int WAYS   = 2,
    parameter int WORDS  = 16
) (
    input  logic          clk,
    input  logic          reset,
    l1_dcache_sa_if.slave bus
`ifdef L1_DCACHE_STATS_EN
    ,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count
`endif
);

    localparam int OFF_W = off_w(WORDS);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, SETS, WORDS);

    state_e state_q, state_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [OFF_W:0]    beat_q;
    logic              victim_q;
    logic              flush_pend_q;
    logic [SETS-1:0]   lru_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] data_q [WAYS][SETS][WORDS];

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    logic [WAYS-1:0]   hit_vec;
    logic [WAYS-1:0]   valid_vec;
    logic [WAYS-1:0]   fill_vec;
    logic              hit_any;
    logic              hit_way;
    logic              victim;
    logic [DATA_W-1:0] rd_word;

    logic go;
    logic accept;
    logic clear_all;
    logic do_lookup;
    logic ld_hit;
    logic st_hit;
    logic ld_miss;
    logic st_look;
    logic beat_en;
    logic fill_done;

    assign off = addr_q[OFF_W-1:0];
    assign idx = addr_q[OFF_W +: IDX_W];
    assign tag = addr_q[ADDR_W-1 -: TAG_W];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        l1_tag_way #(
            .SETS  (SETS),
            .TAG_W (TAG_W)
        ) u_way (
            .clk       (clk),
            .reset     (reset),
            .clear_all (clear_all),
            .wr_en     (fill_vec[w]),
            .idx       (idx),
            .tag       (tag),
            .hit       (hit_vec[w]),
            .valid     (valid_vec[w])
        );
    end

    assign hit_any = |hit_vec;
    assign hit_way = (WAYS == 2) ? hit_vec[WAYS-1] : 1'b0;
    assign rd_word = data_q[hit_way][idx][off];

    // Lowest invalid way first, otherwise the set's LRU way.
    always_comb begin
        victim = 1'b0;
        if (WAYS == 2) begin
            if (!valid_vec[0]) begin
                victim = 1'b0;
            end else if (!valid_vec[WAYS-1]) begin
                victim = 1'b1;
            end else begin
                victim = lru_q[idx];
            end
        end
    end

    // l2_busy freezes every state, counter and array update.
    assign go        = !bus.l2_busy;
    assign clear_all = go && (state_q == ST_IDLE)
                     && (bus.flush || flush_pend_q);
    assign accept    = bus.req_valid && bus.req_ready;
    assign do_lookup = go && (state_q == ST_LOOKUP);
    assign ld_hit    = do_lookup && !we_q && hit_any;
    assign st_hit    = do_lookup && we_q && hit_any;
    assign ld_miss   = do_lookup && !we_q && !hit_any;
    assign st_look   = do_lookup && we_q;
    assign beat_en   = go && (state_q == ST_REFILL) && bus.l2_rd_valid;
    assign fill_done = beat_en
                     && (beat_q == (OFF_W+1)'(WORDS-1));

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            fill_vec[w] = fill_done && (int'(victim_q) == w);
        end
    end

    // Busy also masks ready so a handshake is never lost while frozen.
    assign bus.req_ready  = (state_q == ST_IDLE) && !bus.flush
                          && !flush_pend_q && go;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.l2_rd_req  = (state_q == ST_REFILL);
    assign bus.l2_rd_addr = rd_addr_q;
    assign bus.l2_wr_req  = (state_q == ST_WRITE);
    assign bus.l2_wr_addr = wr_addr_q;
    assign bus.l2_wr_data = wr_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (go) begin
                    if (we_q) begin
                        state_d = ST_WRITE;
                    end else if (hit_any) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                if (fill_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: begin
                if (go && bus.l2_wr_ack) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (go) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            beat_q       <= '0;
            victim_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            lru_q        <= '0;
            rdata_q      <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (ld_hit) begin
                rdata_q <= rd_word;
            end
            if (ld_miss) begin
                victim_q  <= victim;
                rd_addr_q <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                beat_q    <= '0;
            end
            if (st_look) begin
                wr_addr_q <= addr_q;
                wr_data_q <= wdata_q;
            end
            if (beat_en) begin
                if (beat_q[OFF_W-1:0] == off) begin
                    rdata_q <= bus.l2_rd_data;
                end
                beat_q <= fill_done ? '0 : beat_q + 1'b1;
            end
            // The pulse is remembered even while frozen so it is not lost.
            if (clear_all) begin
                flush_pend_q <= 1'b0;
            end else if (bus.flush) begin
                flush_pend_q <= 1'b1;
            end
            if (clear_all) begin
                lru_q <= '0;
            end else if (ld_hit || st_hit) begin
                lru_q[idx] <= ~hit_way;
            end else if (fill_done) begin
                lru_q[idx] <= ~victim_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (st_hit) begin
            data_q[hit_way][idx][off] <= wdata_q;
        end
        if (beat_en) begin
            data_q[victim_q][idx][beat_q[OFF_W-1:0]] <= bus.l2_rd_data;
        end
    end

`ifdef L1_DCACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (do_lookup) begin
            if (hit_any) begin
                if (hit_count != 16'hFFFF) begin
                    hit_count <= hit_count + 16'd1;
                end
            end else begin
                if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_dcache_sa.sv
// Scoreboard bench for l1_dcache_sa: directed loads/stores, flush, stall
// and reset scenarios against a behavioural L2 model.
module tb_l1_dcache_sa;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l1_dcache_sa_if bus ();

`ifdef L1_DCACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    int exp_hits;
    int exp_miss;
`endif

    l1_dcache_sa dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef L1_DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        bit          chk;
        int          refills;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [14:0] a;
        logic [31:0] d;
    } wr_t;

    exp_t        sb [$];
    wr_t         wq [$];
    logic [31:0] wmem [int];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int refills = 0;
    int exp_refills = 0;
    int beat = 0;
    int wcnt = 0;
    logic [14:0] exp_base = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [14:0] a);
        if (wmem.exists(int'(a))) return wmem[int'(a)];
        if (a[14:4] == 11'h012) return 32'hA0 + {28'h0, a[3:0]};
        return {17'h0, a} ^ 32'h5A5A_0000;
    endfunction

    // L2 model: one beat per cycle while requested, ack on 3rd write cycle.
    initial begin
        bus.l2_rd_valid = 1'b0;
        bus.l2_rd_data  = '0;
        bus.l2_wr_ack   = 1'b0;
        forever begin
            @(negedge clk);
            bus.l2_rd_valid = 1'b0;
            bus.l2_wr_ack   = 1'b0;
            if (reset) begin
                beat = 0;
                wcnt = 0;
            end else begin
                if (!bus.l2_rd_req) begin
                    beat = 0;
                end else if (!bus.l2_busy && beat < 16) begin
                    if (beat == 0) begin
                        refills++;
                        chk("rd_base", 32'(bus.l2_rd_addr), 32'(exp_base));
                    end
                    bus.l2_rd_valid = 1'b1;
                    bus.l2_rd_data  = mem(bus.l2_rd_addr + 15'(beat));
                    beat++;
                end
                if (!bus.l2_wr_req) begin
                    wcnt = 0;
                end else if (!bus.l2_busy) begin
                    wcnt++;
                    if (wcnt == 3) begin
                        wr_t w;
                        bus.l2_wr_ack = 1'b1;
                        if (wq.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL wr_unexpected: got %h want none",
                                     bus.l2_wr_addr);
                        end else begin
                            w = wq.pop_front();
                            chk("wr_addr", 32'(bus.l2_wr_addr), 32'(w.a));
                            chk("wr_data", bus.l2_wr_data, w.d);
                        end
                        wmem[int'(bus.l2_wr_addr)] = bus.l2_wr_data;
                    end
                end
            end
        end
    end

    // Response monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.resp_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp_spurious: got 1 want 0");
                end else begin
                    e = sb.pop_front();
                    if (e.chk) chk("rdata", bus.resp_rdata, e.rdata);
                    chk("refills", 32'(refills), 32'(e.refills));
                    if (e.lat > 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_beats(input int k);
        int n = 0;
        while (beat < k && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (beat < k) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: got %0d want %0d", beat, k);
        end
    endtask

    // lat = edges from accept to the edge entering RESP (0 = unchecked).
    task automatic do_req(input bit we, input logic [14:0] a,
                          input logic [31:0] d, input logic [31:0] er,
                          input bit hit, input int lat, input bit wait_done);
        exp_t e;
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout %h: got 0 want 1", a);
            bus.req_valid = 1'b0;
            return;
        end
        if (!we && !hit) begin
            exp_refills++;
            exp_base = {a[14:4], 4'h0};
        end
        if (we) wq.push_back('{a: a, d: d});
`ifdef L1_DCACHE_STATS_EN
        if (hit) exp_hits++;
        else exp_miss++;
`endif
        e.rdata   = er;
        e.chk     = !we;
        e.refills = exp_refills;
        e.lat     = lat;
        e.acc     = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        if (wait_done) wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.flush     = 1'b0;
        bus.l2_busy   = 1'b0;
`ifdef L1_DCACHE_STATS_EN
        exp_hits = 0;
        exp_miss = 0;
`endif
        #3;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_l2_rd_req", 32'(bus.l2_rd_req), 32'd0);
        chk("rst_l2_wr_req", 32'(bus.l2_wr_req), 32'd0);
        chk("rst_l2_rd_addr", 32'(bus.l2_rd_addr), 32'd0);
        chk("rst_l2_wr_addr", 32'(bus.l2_wr_addr), 32'd0);
        chk("rst_l2_wr_data", bus.l2_wr_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_req(0, 15'h0123, 0, 32'h0000_00A3, 0, 0, 1);
        do_req(0, 15'h0123, 0, 32'h0000_00A3, 1, 1, 1);
        do_req(0, 15'h0010, 0, 32'h5A5A_0010, 0, 0, 1);
        do_req(0, 15'h0210, 0, 32'h5A5A_0210, 0, 0, 1);
        do_req(0, 15'h0410, 0, 32'h5A5A_0410, 0, 0, 1);
        do_req(0, 15'h0210, 0, 32'h5A5A_0210, 1, 1, 1);
        do_req(0, 15'h0010, 0, 32'h5A5A_0010, 0, 0, 1);

        do_req(1, 15'h0125, 32'hDEAD_BEEF, 0, 1, 0, 1);
        do_req(0, 15'h0125, 0, 32'hDEAD_BEEF, 1, 1, 1);
        do_req(1, 15'h7000, 32'h1234_5678, 0, 0, 0, 1);
        do_req(0, 15'h7000, 0, 32'h1234_5678, 0, 0, 1);

        do_req(0, 15'h0333, 0, 32'h5A5A_0333, 0, 0, 0);
        wait_beats(4);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        wait_idle();
        do_req(0, 15'h0123, 0, 32'h0000_00A3, 0, 0, 1);
        do_req(0, 15'h0333, 0, 32'h5A5A_0333, 0, 0, 1);

        do_req(0, 15'h0444, 0, 32'h5A5A_0444, 0, 0, 0);
        wait_beats(5);
        @(posedge clk);
        #1 bus.l2_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("busy_rd_req", 32'(bus.l2_rd_req), 32'd1);
            chk("busy_rd_addr", 32'(bus.l2_rd_addr), 32'h0440);
            chk("busy_resp", 32'(bus.resp_valid), 32'd0);
        end
        @(posedge clk);
        #1 bus.l2_busy = 1'b0;
        wait_idle();

        do_req(0, 15'h0444, 0, 32'h5A5A_0444, 1, 4, 0);
        bus.l2_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.l2_busy = 1'b0;
        wait_idle();

        do_req(0, 15'h0555, 0, 32'h5A5A_0555, 0, 0, 0);
        wait_beats(7);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        sb.delete();
`ifdef L1_DCACHE_STATS_EN
        exp_hits = 0;
        exp_miss = 0;
`endif
        chk("mid_rst_rd_req", 32'(bus.l2_rd_req), 32'd0);
        chk("mid_rst_rd_addr", 32'(bus.l2_rd_addr), 32'd0);
        chk("mid_rst_resp", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        #1 reset = 1'b0;
        do_req(0, 15'h0555, 0, 32'h5A5A_0555, 0, 0, 1);
        do_req(0, 15'h0123, 0, 32'h0000_00A3, 0, 0, 1);
        do_req(0, 15'h0123, 0, 32'h0000_00A3, 1, 1, 1);
        do_req(0, 15'h0555, 0, 32'h5A5A_0555, 1, 1, 1);
        do_req(0, 15'h0550, 0, 32'h5A5A_0550, 1, 1, 1);

`ifdef L1_DCACHE_STATS_EN
        chk("hit_count", 32'(hit_count), 32'(exp_hits));
        chk("miss_count", 32'(miss_count), 32'(exp_miss));
`endif
        chk("wq_drained", 32'(wq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1_dcache_sa.md
# l1_dcache_sa

Parametrised, set-associative, write-through / no-write-allocate L1 data cache between the core load/store unit and the shared L2. Generalises the first-generation direct-mapped L1: configurable sets, ways (1 or 2), block size and address width, with a valid/ready request handshake, LRU replacement, word-serial refill with a per-beat valid, acknowledged write-through, and deferred flush.

## Interface
- ADDR_W, 15, word-address width
- DATA_W, 32, data word width
- SETS, 32, sets (power of 2, ≥2)
- WAYS, 2, associativity (1 or 2)
- WORDS, 16, words per block (power of 2, ≥2)
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request present
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- req_ready  out  1  request accepted when req_valid & req_ready
- resp_valid  out  1  one-cycle completion pulse (load and store)
- resp_rdata  out  DATA_W  load data, valid with resp_valid
- flush  in  1  single-cycle invalidate-all request
- l2_busy  in  1  global stall: FSM, counters, arrays frozen
- l2_rd_req  out  1  block refill request, held until last beat
- l2_rd_addr  out  ADDR_W  block base address (offset bits 0)
- l2_rd_valid  in  1  refill beat present
- l2_rd_data  in  DATA_W  refill word, beats in ascending offset order
- l2_wr_req  out  1  write-through request, held until ack
- l2_wr_addr  out  ADDR_W  store word address
- l2_wr_data  out  DATA_W  store word
- l2_wr_ack  in  1  write accepted by L2

## Operation
- Address split: OFF_W=log2(WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W−IDX_W−OFF_W (default 6/5/4 → tag 6).
- States: IDLE, LOOKUP, REFILL, WRITE, RESP.
- IDLE: req_ready=1 unless flush or flush_pending; on accept, latch we/addr/wdata → LOOKUP.
- LOOKUP: compare tag against all valid ways of set.
  - Load hit: register word into resp_rdata, update LRU → RESP.
  - Load miss: choose victim (lowest invalid way, else LRU way) → REFILL.
  - Store hit: write word into hit way, update LRU → WRITE.
  - Store miss: no allocate, no array change → WRITE.
- REFILL: l2_rd_req=1; each l2_rd_valid beat writes beat_cnt word of victim, beat_cnt+1 (OFF_W+1 bits). After beat WORDS−1: set tag, valid, LRU; resp_rdata = requested word (captured from matching beat) → RESP.
- WRITE: l2_wr_req=1 with latched addr/data; on l2_wr_ack → RESP.
- RESP: resp_valid=1 one cycle → IDLE.
- LRU (WAYS=2): one bit per set, set to the way not accessed on hit or fill; WAYS=1 ignores it.
- flush: pulse in any state sets flush_pending; in IDLE, pending or live flush clears all valid and LRU bits at next edge, taking priority over req_valid (req_ready=0 that cycle). Refill/write in flight always completes first.
- l2_busy=1: no state change, array write, counter increment or beat capture; outputs hold. Beats arriving while l2_busy=1 are a protocol error (L2 never does this).

## Timing
- Reset (async): state IDLE, all valid/LRU 0, beat_cnt 0, flush_pending 0; req_ready=1, resp_valid=0, resp_rdata=0, l2_rd_req=0, l2_wr_req=0, l2_rd_addr=0, l2_wr_addr=0, l2_wr_data=0. Reset mid-refill/write drops L2 requests immediately; partial block never marked valid.
- Load hit: accept edge T, resp_valid in cycle T+2 (2-cycle latency), next accept at T+3.
- Load miss: resp_valid 1 cycle after edge capturing last beat; minimum WORDS+3 cycles.
- Store: resp_valid 1 cycle after l2_wr_ack edge; l2_wr_req rises cycle after LOOKUP.
- Request outputs are registered-state decodes; no combinational path from L2 inputs to request outputs.

## Configuration
- L1_DCACHE_STATS_EN defined: adds outputs hit_count, miss_count (16 bits, saturating at 0xFFFF, increment in LOOKUP, cleared by reset and not by flush).
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package l1_cache_pkg: state enum, address-field width functions, line-metadata struct (valid, tag).
- Sub-module l1_tag_way: one way's valid/tag array with compare output, instantiated WAYS times.

## Test plan
- Load 0x0123 cold (WAYS=2): one refill from base 0x0120, 16 beats data 0xA0+i → resp_rdata=0xA3; repeat load → hit, resp at T+2, no l2_rd_req.
- Loads 0x0010, 0x0210, 0x0410 (same set 1): third evicts way holding 0x0010; load 0x0210 still hits, 0x0010 misses.
- Store 0x0125=0xDEADBEEF after fill → l2_wr_req addr 0x0125 data 0xDEADBEEF held 3 cycles until ack; subsequent load 0x0125 hits returning 0xDEADBEEF. Store to uncached 0x7000 → write-through only, later load 0x7000 misses.
- flush pulsed mid-refill → refill completes, resp delivered, then all lines invalid; next load misses.
- l2_busy held 5 cycles mid-refill → beat_cnt and outputs frozen; reset asserted at beat 7 → l2_rd_req low immediately, reload misses.
- With L1_DCACHE_STATS_EN: 3 hits + 2 misses → hit_count=3, miss_count=2.
